// File: rtl/posit_arb_pkg.sv
// Shared types and constants for the posit multiplier arbiter.
// Provides the FSM state encoding and the posit special values.
// nar_of()/zero_of() give the special encodings for any width up to 64 bits.
package posit_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Default posit width; the top derives its own constants from its N.
  localparam int POSIT_N = 32;

  // NaR is a sign bit set over all-zero magnitude; zero is all zeros.
  function automatic logic [63:0] nar_of(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] zero_of(input int n);
    return (n > 0) ? 64'd0 : 64'd0;
  endfunction

  localparam logic [POSIT_N-1:0] NAR  = POSIT_N'(nar_of(POSIT_N));
  localparam logic [POSIT_N-1:0] ZERO = POSIT_N'(zero_of(POSIT_N));

endpackage

// File: rtl/posit_rr_arb.sv
// Purpose: 2-way round-robin winner selection, purely combinational.
// Latency: 0 cycles. Backpressure: none; the caller decides when the winner is accepted.
// Ports: valid0/valid1 requests, last = port granted most recently, win_valid/win = winner.
module posit_rr_arb (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic win_valid,
  output logic win
);

  always_comb begin
    win_valid = valid0 | valid1;
    // On contention the port that was not granted last time goes first.
    if (valid0 && valid1) begin
      win = ~last;
    end else begin
      win = valid1;
    end
  end

endmodule

// File: rtl/posit_mult_arbiter.sv
// Purpose: shares one external posit multiplier between two request/response ports.
// Latency: 1 cycle handshake->rsp_valid for NaR/zero operands, 2+L for normal ones.
// Backpressure: one op in flight; req ready stays low until the granted rsp is taken.
// Ports: req0/req1 (valid/ready/a/b), rsp0/rsp1 (valid/ready/data), mul_* to the
// multiplier, busy. Defining POSIT_ARB_STATS_EN adds grant_cnt0/grant_cnt1.
module posit_mult_arbiter
  import posit_arb_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_a,
  input  logic [N-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_a,
  input  logic [N-1:0]  req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [N-1:0]  rsp0_data,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [N-1:0]  rsp1_data,
  output logic          mul_start,
  output logic [N-1:0]  mul_a,
  output logic [N-1:0]  mul_b,
  input  logic          mul_done,
  input  logic [N-1:0]  mul_result,
`ifdef POSIT_ARB_STATS_EN
  output logic [CW-1:0] grant_cnt0,
  output logic [CW-1:0] grant_cnt1,
`endif
  output logic          busy
);

  localparam logic [N-1:0] NAR_N  = N'(nar_of(N));
  localparam logic [N-1:0] ZERO_N = N'(zero_of(N));

  // The exponent field must leave room for sign and at least one regime bit.
  if (ES > N - 2) begin : g_bad_es
    $error("posit_mult_arbiter: ES too large for N");
  end

  arb_state_t   state, state_nxt;
  logic         last_q, gnt_q;
  logic [N-1:0] a_q, b_q, res_q;

  logic         win_valid, win;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_nar, sel_zero;
  logic         accept;
  logic         rsp_taken;

  posit_rr_arb u_rr_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (last_q),
    .win_valid (win_valid),
    .win       (win)
  );

  assign sel_a     = win ? req1_a : req0_a;
  assign sel_b     = win ? req1_b : req0_b;
  assign sel_nar   = (sel_a == NAR_N) || (sel_b == NAR_N);
  assign sel_zero  = (sel_a == ZERO_N) || (sel_b == ZERO_N);
  assign accept    = (state == IDLE) && win_valid;
  assign rsp_taken = gnt_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mul_start  = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = win_valid && !win;
        req1_ready = win_valid && win;
        if (win_valid) begin
          // NaR/zero products are known without the multiplier.
          state_nxt = (sel_nar || sel_zero) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp0_valid = !gnt_q;
        rsp1_valid = gnt_q;
        if (rsp_taken) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        gnt_q  <= win;
        last_q <= win;
        if (sel_nar) begin
          res_q <= NAR_N;
        end else if (sel_zero) begin
          res_q <= ZERO_N;
        end
      end
      if ((state == WAIT) && mul_done) begin
        res_q <= mul_result;
      end
    end
  end

  // Operand registers only change on an IDLE accept, so they stay stable from
  // ISSUE until the multiplier reports done.
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp0_data = rsp0_valid ? res_q : '0;
  assign rsp1_data = rsp1_valid ? res_q : '0;
  assign busy      = (state != IDLE);

`ifdef POSIT_ARB_STATS_EN
  // Counters wrap naturally at 2^CW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (win) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end else begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Bench for posit_mult_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model with a stub multiplier.
module tb_posit_mult_arbiter;

  localparam int N  = 32;
  localparam int ES = 4;
  localparam int CW = 4;
  localparam logic [31:0] NAR_C = 32'h8000_0000;
  localparam logic [31:0] ONE_C = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        mul_start, mul_done, busy;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  posit_mult_arbiter #(.N(N), .ES(ES), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
`ifdef POSIT_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

`ifndef POSIT_ARB_STATS_EN
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

  // Stub multiplier: any deterministic function works, 1.0 is the identity.
  function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == ONE_C) return b;
    if (b == ONE_C) return a;
    return a ^ {b[30:0], b[31]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR_C || b == NAR_C) return NAR_C;
    if (a == 32'd0 || b == 32'd0) return 32'd0;
    return stub_fn(a, b);
  endfunction

  function automatic logic [31:0] rand_operand();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return NAR_C;
    if (r == 1) return 32'd0;
    if (r == 2) return ONE_C;
    return $urandom;
  endfunction

  int          stub_cnt = 0;
  int          stub_lat = 3;
  int          start_cnt = 0;
  logic [31:0] stub_res = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      stub_cnt  <= stub_lat;
      stub_res  <= stub_fn(mul_a, mul_b);
      start_cnt <= start_cnt + 1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign mul_done   = (stub_cnt == 1);
  assign mul_result = stub_res;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits for its handshake, then counts cycles until
  // the matching response is valid. Returns with the response still pending.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, output int lat, output int starts,
                        output logic [31:0] data);
    int n;
    int s0;
    logic normal;
    normal = !(a == NAR_C || b == NAR_C || a == 32'd0 || b == 32'd0);
    rsp0_ready = rdy; rsp1_ready = rdy;
    if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; end
    #1;
    n = 0;
    while (!(port == 0 ? req0_ready : req1_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("op_accept", (n < 20), 1);
    s0 = start_cnt;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    #1;
    lat = 1;
    while (!(port == 0 ? rsp0_valid : rsp1_valid) && lat < 30) begin
      if (normal) begin
        check("mul_a_hold", mul_a, a);
        check("mul_b_hold", mul_b, b);
      end
      @(posedge clk); #1; lat++;
    end
    starts = start_cnt - s0;
    data = (port == 0) ? rsp0_data : rsp1_data;
  endtask

  initial begin
    int lat, starts, ng, n;
    logic [31:0] data, held;
    int g[4];
    bit any_rsp, any_busy;

    // ---------------- reset state ----------------
    rst_n = 0;
    clear_inputs();
    req0_valid = 1; req0_a = ONE_C; req0_b = ONE_C;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    check("rst_grant_cnt", {grant_cnt0, grant_cnt1}, 0);
    do_reset();

    // ---------------- single normal op, L=3 ----------------
    stub_lat = 3;
    run_op(0, ONE_C, ONE_C, 1'b1, lat, starts, data);
    check("single_lat", lat, 5);
    check("single_starts", starts, 1);
    check("single_data", data, ONE_C);
    check("single_rsp1_quiet", {rsp1_valid, rsp1_data}, 0);
    @(posedge clk); #1;
    check("single_done_idle", {busy, rsp0_valid}, 0);

    // ---------------- backpressure ----------------
    run_op(0, 32'h4800_0000, 32'h3C00_0000, 1'b0, lat, starts, data);
    check("bp_lat", lat, 5);
    check("bp_data", data, stub_fn(32'h4800_0000, 32'h3C00_0000));
    held = data;
    req1_valid = 1; req1_a = ONE_C; req1_b = 32'h5000_0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", rsp0_valid, 1);
      check("bp_data_stable", rsp0_data, held);
      check("bp_busy", busy, 1);
      check("bp_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    req1_valid = 0;
    rsp0_ready = 1;
    @(posedge clk); #1;
    check("bp_release", {busy, rsp0_valid}, 0);

    // ---------------- special operands ----------------
    run_op(1, NAR_C, 32'd0, 1'b1, lat, starts, data);
    check("nar_lat", lat, 1);
    check("nar_starts", starts, 0);
    check("nar_data", data, NAR_C);
    check("nar_rsp0_quiet", {rsp0_valid, rsp0_data}, 0);
    @(posedge clk); #1;
    run_op(1, 32'd0, ONE_C, 1'b1, lat, starts, data);
    check("zero_lat", lat, 1);
    check("zero_starts", starts, 0);
    check("zero_data", data, 0);
    @(posedge clk); #1;

    // ---------------- contention from reset ----------------
    do_reset();
    stub_lat = 1;
    req0_valid = 1; req0_a = 32'h4400_0000; req0_b = 32'h4200_0000;
    req1_valid = 1; req1_a = 32'h3800_0000; req1_b = 32'h4600_0000;
    ng = 0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      #1;
      if (req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      @(posedge clk); #1;
    end
    clear_inputs();
    check("cont_count", ng, 4);
    for (int i = 0; i < 4; i++) check("cont_order", (i < ng) ? g[i] : 9, i % 2);
    n = 0;
    while (busy && n < 30) begin @(posedge clk); #1; n++; end
    check("cont_drain", busy, 0);

    // ---------------- reset in WAIT ----------------
    do_reset();
    stub_lat = 8;
    req0_valid = 1; req0_a = 32'h4400_0000; req0_b = 32'h4400_0000;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_rsp", {rsp0_valid, rsp1_valid}, 0);
    check("rstw_mul_a", mul_a, 0);
    @(posedge clk); #1;
    rst_n = 1;
    any_rsp = 0; any_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      any_rsp  = any_rsp | rsp0_valid | rsp1_valid;
      any_busy = any_busy | busy;
    end
    check("rstw_no_rsp", any_rsp, 0);
    check("rstw_idle", any_busy, 0);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    begin
      logic [31:0] q0[$], q1[$];
      bit pend0, pend1, hsd0, hsd1, infl, drain, h0, h1;
      int last_m, ops, exp_w, got_w;
      pend0 = 0; pend1 = 0; hsd0 = 0; hsd1 = 0; infl = 0; drain = 0;
      last_m = 1; ops = 0;
      for (int c = 0; c < 8000; c++) begin
        drain = (ops >= 150);
        if (hsd0) begin req0_valid = 0; pend0 = 0; hsd0 = 0; end
        if (hsd1) begin req1_valid = 0; pend1 = 0; hsd1 = 0; end
        if (drain && !pend0 && !pend1 && !infl) break;
        if (!pend0 && !drain && $urandom_range(0, 2) == 0) begin
          pend0 = 1; req0_valid = 1; req0_a = rand_operand(); req0_b = rand_operand();
        end
        if (!pend1 && !drain && $urandom_range(0, 2) == 0) begin
          pend1 = 1; req1_valid = 1; req1_a = rand_operand(); req1_b = rand_operand();
        end
        rsp0_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        rsp1_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        stub_lat = $urandom_range(1, 4);
        #1;
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        if (infl) begin
          check("rnd_ready_busy", {req0_ready, req1_ready}, 0);
        end else if (req0_valid || req1_valid) begin
          exp_w = (req0_valid && req1_valid) ? (last_m == 0 ? 1 : 0) : (req1_valid ? 1 : 0);
          got_w = h1 ? 1 : (h0 ? 0 : 2);
          check("rnd_rr_winner", got_w, exp_w);
          if (h0 || h1) begin
            last_m = got_w;
            infl = 1;
            if (h1) begin q1.push_back(exp_result(req1_a, req1_b)); hsd1 = 1; end
            else begin q0.push_back(exp_result(req0_a, req0_b)); hsd0 = 1; end
          end
        end
        if (rsp0_valid && rsp1_valid) check("rnd_both_rsp", 1, 0);
        if (!rsp0_valid && rsp0_data != 0) check("rnd_rsp0_idle_data", rsp0_data, 0);
        if (!rsp1_valid && rsp1_data != 0) check("rnd_rsp1_idle_data", rsp1_data, 0);
        if (rsp0_valid && rsp0_ready) begin
          if (q0.size() == 0) check("rnd_rsp0_unexpected", 1, 0);
          else check("rnd_rsp0_data", rsp0_data, q0.pop_front());
          infl = 0; ops++;
        end
        if (rsp1_valid && rsp1_ready) begin
          if (q1.size() == 0) check("rnd_rsp1_unexpected", 1, 0);
          else check("rnd_rsp1_data", rsp1_data, q1.pop_front());
          infl = 0; ops++;
        end
        @(posedge clk); #1;
      end
      check("rnd_ops", (ops >= 150), 1);
      check("rnd_drained", {pend0, pend1, infl}, 0);
      check("rnd_queues", q0.size() + q1.size(), 0);
    end
    clear_inputs();

`ifdef POSIT_ARB_STATS_EN
    // ---------------- grant counter wrap ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_op(0, 32'd0, ONE_C, 1'b1, lat, starts, data);
      @(posedge clk); #1;
    end
    check("stats_cnt0_wrap", grant_cnt0, 1);
    check("stats_cnt1", grant_cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
